// File: rtl/channel_frontend.sv
// rtl/channel_frontend.sv - A/B parallel channel frontend: sync, tag filter, outbound regs, driver sequencing, parity
// Purpose: turns the active-low A-side receiver lines into active-high B-side
//   signals, glitch-filters inbound tags, registers the outbound bus/tags, and
//   sequences the line-driver enable. Inbound parity is checked with a saturating counter.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   enable, wrap_test, clear_errors  frontend enable, forced driver request, error clear
//   a_bus_in_n/_parity_n, a_tag_in_n A-side inbound pins (active-low)
//   b_bus_in/_parity, b_tag_in       B-side inbound (active-high, tags filtered)
//   b_bus_out/_parity, b_tag_out     B-side outbound from the protocol engine
//   a_bus_out/_parity, a_tag_out     A-side outbound, registered
//   driver_enable                    line-driver enable after the turn-on delay
//   parity_error, error_count        bad-parity pulse and saturating count
module channel_frontend #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int DRIVER_DELAY  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  wrap_test,
  input  logic                  clear_errors,
  input  logic [DATA_WIDTH-1:0] a_bus_in_n,
  input  logic                  a_bus_in_parity_n,
  input  logic [9:0]            a_tag_in_n,
  output logic [DATA_WIDTH-1:0] b_bus_in,
  output logic                  b_bus_in_parity,
  output logic [9:0]            b_tag_in,
  input  logic [DATA_WIDTH-1:0] b_bus_out,
  input  logic                  b_bus_out_parity,
  input  logic [11:0]           b_tag_out,
  output logic [DATA_WIDTH-1:0] a_bus_out,
  output logic                  a_bus_out_parity,
  output logic [11:0]           a_tag_out,
  output logic                  driver_enable,
  output logic                  parity_error,
  output logic [7:0]            error_count
);

  localparam int IW  = DATA_WIDTH + 11;
  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam int DCW = $clog2(DRIVER_DELAY + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [DCW-1:0] DLY_LAST  = DCW'(DRIVER_DELAY - 1);

  typedef enum logic [1:0] {ST_OFF, ST_DELAY, ST_ON} drv_state_e;

  // Inbound synchroniser: {tags, parity, bus}, idle level is all-ones.
  logic [IW-1:0]         sync_q [SYNC_STAGES];
  logic [IW-1:0]         synced;
  logic [DATA_WIDTH:0]   s_bus;
  logic [9:0]            s_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {a_tag_in_n, a_bus_in_parity_n, a_bus_in_n};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign s_bus  = synced[DATA_WIDTH:0];
  assign s_tag  = synced[IW-1:DATA_WIDTH+1];

  // Tag filter, kept in the active-low pin polarity. The flip happens on the
  // edge the counter would reach FILTER_CYCLES, so it never holds that value.
  logic [9:0]     filt_q, filt_d;
  logic [FCW-1:0] fcnt_q [10];
  logic [FCW-1:0] fcnt_d [10];

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 10; i++) begin
      fcnt_d[i] = '0;
      if (s_tag[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          filt_d[i] = ~filt_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCW'(1);
        end
      end
    end
  end

  // Registered datapath and parity checker.
  logic [DATA_WIDTH:0] bus_in_q, bus_in_d;
  logic [9:0]          tag_in_q, tag_in_d;
  logic [DATA_WIDTH:0] bus_out_q, bus_out_d;
  logic [11:0]         tag_out_q, tag_out_d;
  logic [1:0]          tag_prev_q;
  logic                perr_q, perr_d;
  logic [7:0]          ecnt_q, ecnt_d;
  logic                svc_rise;

  always_comb begin
    bus_in_d  = enable ? ~s_bus : '0;
    // Select bypass: with the frontend disabled, select-in follows select-out.
    tag_in_d  = enable ? ~filt_q : {7'b0, 1'b0, tag_out_q[2], 1'b0};
    bus_out_d = enable ? {b_bus_out_parity, b_bus_out} : '0;
    // Bit 11 is reserved and always driven low.
    tag_out_d = enable ? (b_tag_out & 12'h7FF) : '0;

    // Service-in or data-in rising: the bus has already been stable for the
    // filter window, so the currently registered bus is the sample to check.
    svc_rise  = enable & (|(tag_in_q[6:5] & ~tag_prev_q));
    perr_d    = svc_rise & ~(^bus_in_q);

    ecnt_d = ecnt_q;
    if (clear_errors) begin
      ecnt_d = '0;
    end else if (perr_d && (ecnt_q != 8'hFF)) begin
      ecnt_d = ecnt_q + 8'd1;
    end
  end

  // Driver sequencing.
  drv_state_e     state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           drv_q, drv_d;
  logic           req;

  assign req = enable & (tag_out_q[0] | wrap_test);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_OFF: begin
        dcnt_d = '0;
        if (req) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (!req) begin
          state_d = ST_OFF;
        end else if (dcnt_q == DLY_LAST) begin
          state_d = ST_ON;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      ST_ON: begin
        if (!req) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    // Gated by req so a dropped request clears the driver on the same edge
    // that takes the FSM out of ON.
    drv_d = (state_q == ST_ON) & req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= '1;
      for (int i = 0; i < 10; i++) fcnt_q[i] <= '0;
      bus_in_q   <= '0;
      tag_in_q   <= '0;
      bus_out_q  <= '0;
      tag_out_q  <= '0;
      tag_prev_q <= '0;
      perr_q     <= 1'b0;
      ecnt_q     <= '0;
      state_q    <= ST_OFF;
      dcnt_q     <= '0;
      drv_q      <= 1'b0;
    end else begin
      filt_q     <= filt_d;
      for (int i = 0; i < 10; i++) fcnt_q[i] <= fcnt_d[i];
      bus_in_q   <= bus_in_d;
      tag_in_q   <= tag_in_d;
      bus_out_q  <= bus_out_d;
      tag_out_q  <= tag_out_d;
      tag_prev_q <= tag_in_q[6:5];
      perr_q     <= perr_d;
      ecnt_q     <= ecnt_d;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      drv_q      <= drv_d;
    end
  end

  assign b_bus_in         = bus_in_q[DATA_WIDTH-1:0];
  assign b_bus_in_parity  = bus_in_q[DATA_WIDTH];
  assign b_tag_in         = tag_in_q;
  assign a_bus_out        = bus_out_q[DATA_WIDTH-1:0];
  assign a_bus_out_parity = bus_out_q[DATA_WIDTH];
  assign a_tag_out        = tag_out_q;
  assign driver_enable    = drv_q;
  assign parity_error     = perr_q;
  assign error_count      = ecnt_q;

endmodule

// File: tb/tb_channel_frontend.sv
// tb/tb_channel_frontend.sv - self-checking bench for channel_frontend with a cycle-history reference model
module tb_channel_frontend;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int FC = 3;
  localparam int DD = 4;
  localparam int MAXN = 8192;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable, wrap_test, clear_errors;
  logic [DW-1:0] a_bus_in_n;
  logic          a_bus_in_parity_n;
  logic [9:0]    a_tag_in_n;
  logic [DW-1:0] b_bus_in;
  logic          b_bus_in_parity;
  logic [9:0]    b_tag_in;
  logic [DW-1:0] b_bus_out;
  logic          b_bus_out_parity;
  logic [11:0]   b_tag_out;
  logic [DW-1:0] a_bus_out;
  logic          a_bus_out_parity;
  logic [11:0]   a_tag_out;
  logic          driver_enable, parity_error;
  logic [7:0]    error_count;
  logic [49:0]   all_out;

  channel_frontend #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .DRIVER_DELAY(DD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .wrap_test(wrap_test),
    .clear_errors(clear_errors), .a_bus_in_n(a_bus_in_n),
    .a_bus_in_parity_n(a_bus_in_parity_n), .a_tag_in_n(a_tag_in_n),
    .b_bus_in(b_bus_in), .b_bus_in_parity(b_bus_in_parity), .b_tag_in(b_tag_in),
    .b_bus_out(b_bus_out), .b_bus_out_parity(b_bus_out_parity), .b_tag_out(b_tag_out),
    .a_bus_out(a_bus_out), .a_bus_out_parity(a_bus_out_parity), .a_tag_out(a_tag_out),
    .driver_enable(driver_enable), .parity_error(parity_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  assign all_out = {b_bus_in, b_bus_in_parity, b_tag_in, a_bus_out, a_bus_out_parity,
                    a_tag_out, driver_enable, parity_error, error_count};

  int checks = 0;
  int errors = 0;

  // Reference model: pin history per edge, expected outputs per edge.
  int          n = 0;
  int          base = 0;
  logic [18:0] pins   [MAXN];
  logic [9:0]  e_btag [MAXN];
  logic [8:0]  e_bbus [MAXN];
  logic [8:0]  e_abus [MAXN];
  logic [11:0] e_atag [MAXN];
  logic        e_perr [MAXN];
  logic        e_drv  [MAXN];
  logic [7:0]  e_cnt  [MAXN];
  logic [9:0]  filt_cur;
  logic [7:0]  cnt_cur;
  int          run_req;

  // Pin value sampled at edge k; before and during reset the lines read idle.
  function automatic logic [18:0] pinv(int k);
    return (k <= base) ? 19'h7FFFF : pins[k];
  endfunction

  // Value leaving the last synchroniser stage after edge m.
  function automatic logic [18:0] syncv(int m);
    return pinv(m - SS + 1);
  endfunction

  task automatic step();
    logic [18:0] s;
    logic [18:0] win [FC];
    logic [9:0]  nf;
    logic        chk, bad, req, all_diff;
    @(posedge clk);
    n++;
    if (n >= MAXN) begin
      $display("FAIL cycle_budget: got %0d cycles, expected < %0d", n, MAXN);
      $fatal(1);
    end
    if (!reset_n) begin
      base = n;
      e_btag[n] = '0; e_bbus[n] = '0; e_abus[n] = '0; e_atag[n] = '0;
      e_perr[n] = 1'b0; e_drv[n] = 1'b0; e_cnt[n] = '0;
      filt_cur = '1; cnt_cur = '0; run_req = 0;
    end else begin
      pins[n]   = {a_tag_in_n, a_bus_in_parity_n, a_bus_in_n};
      e_atag[n] = enable ? {1'b0, b_tag_out[10:0]} : 12'h0;
      e_abus[n] = enable ? {b_bus_out_parity, b_bus_out} : 9'h0;
      s         = syncv(n - 1);
      e_bbus[n] = enable ? ~s[8:0] : 9'h0;
      e_btag[n] = enable ? ~filt_cur : {8'h0, e_atag[n-1][2], 1'b0};
      // A tag level change is accepted once FC consecutive synced samples
      // all disagree with the accepted level.
      for (int j = 1; j <= FC; j++) win[j-1] = syncv(n - j);
      nf = filt_cur;
      for (int b = 0; b < 10; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < FC; j++) if (win[j][9+b] == filt_cur[b]) all_diff = 1'b0;
        if (all_diff) nf[b] = ~filt_cur[b];
      end
      filt_cur = nf;
      chk = enable && ((e_btag[n-1][5] && !e_btag[n-2][5]) ||
                       (e_btag[n-1][6] && !e_btag[n-2][6]));
      bad = ((^e_bbus[n-1]) == 1'b0);
      e_perr[n] = chk && bad;
      if (clear_errors) cnt_cur = 8'd0;
      else if (chk && bad && cnt_cur != 8'd255) cnt_cur = cnt_cur + 8'd1;
      e_cnt[n] = cnt_cur;
      // Driver is on once req has been sampled high on DD+2 consecutive edges.
      req = enable && (e_atag[n-1][0] || wrap_test);
      run_req = req ? run_req + 1 : 0;
      e_drv[n] = (run_req >= DD + 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b1; wrap_test = 1'b0; clear_errors = 1'b0;
    a_bus_in_n = '1; a_bus_in_parity_n = 1'b1; a_tag_in_n = '1;
    b_bus_out = 8'hA5; b_bus_out_parity = 1'b1; b_tag_out = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (all_out !== 50'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %0h, expected 0", all_out);
      end
    end
    reset_n = 1'b1; b_tag_out = '0; b_bus_out = '0; b_bus_out_parity = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (b_tag_in !== 10'h0 || driver_enable !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_tags: got tag %0h drv %0b, expected 0 0", b_tag_in, driver_enable);
      end
    end
  endtask

  task automatic test_tag_latency();
    logic [7:0] exp_bus;
    enable = 1'b1;
    // 0x5A and 0xC3 both have four ones, so parity bit 1 makes them odd.
    a_bus_in_n = ~8'h5A; a_bus_in_parity_n = 1'b0;
    for (int i = 0; i < 6; i++) step();
    a_bus_in_n = ~8'hC3; a_tag_in_n[5] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_bus = (k >= SS + 1) ? 8'hC3 : 8'h5A;
      checks++;
      if (b_bus_in !== exp_bus) begin
        errors++;
        $display("FAIL bus_latency edge %0d: got %0h, expected %0h", k, b_bus_in, exp_bus);
      end
      checks++;
      if (b_tag_in[5] !== (k >= SS + FC + 1)) begin
        errors++;
        $display("FAIL tag_latency edge %0d: got %0b, expected %0b", k, b_tag_in[5], k >= SS + FC + 1);
      end
      checks++;
      if (parity_error !== 1'b0) begin
        errors++;
        $display("FAIL good_parity edge %0d: got %0b, expected 0", k, parity_error);
      end
    end
    a_tag_in_n[5] = 1'b1;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_glitch();
    logic seen;
    seen = 1'b0;
    a_tag_in_n[4] = 1'b0;
    step(); step();
    a_tag_in_n[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); seen |= b_tag_in[4]; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL glitch_2cyc: got %0b, expected 0", seen);
    end
    seen = 1'b0;
    a_tag_in_n[4] = 1'b0;
    step(); step(); step();
    a_tag_in_n[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); seen |= b_tag_in[4]; end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL glitch_3cyc: got %0b, expected 1", seen);
    end
  endtask

  task automatic test_driver();
    logic seen;
    enable = 1'b1; wrap_test = 1'b0; b_tag_out = '0;
    for (int i = 0; i < 3; i++) step();
    b_tag_out[0] = 1'b1;
    step();
    checks++;
    if (a_tag_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL op_out_latency: got %0b, expected 1", a_tag_out[0]);
    end
    // req is first sampled on the edge after operational-out appears.
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (driver_enable !== (k >= DD + 2)) begin
        errors++;
        $display("FAIL drv_turn_on edge %0d: got %0b, expected %0b", k, driver_enable, k >= DD + 2);
      end
    end
    b_tag_out[0] = 1'b0;
    step();
    step();
    checks++;
    if (driver_enable !== 1'b0) begin
      errors++;
      $display("FAIL drv_turn_off: got %0b, expected 0", driver_enable);
    end
    for (int i = 0; i < 3; i++) step();
    b_tag_out[0] = 1'b1;
    step(); step(); step();
    b_tag_out[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); seen |= driver_enable; end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL drv_delay_abort: got %0b, expected 0", seen);
    end
    wrap_test = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (driver_enable !== (k >= DD + 2)) begin
        errors++;
        $display("FAIL drv_wrap edge %0d: got %0b, expected %0b", k, driver_enable, k >= DD + 2);
      end
    end
    enable = 1'b0;
    step();
    checks++;
    if (driver_enable !== 1'b0) begin
      errors++;
      $display("FAIL drv_enable_drop: got %0b, expected 0", driver_enable);
    end
    wrap_test = 1'b0; enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_parity();
    int pulses;
    enable = 1'b1; clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    checks++;
    if (error_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_count: got %0d, expected 0", error_count);
    end
    // Bus 0x01 with parity 1 is even: bad.
    a_bus_in_n = ~8'h01; a_bus_in_parity_n = 1'b0; a_tag_in_n = '1;
    for (int i = 0; i < 5; i++) step();
    pulses = 0;
    a_tag_in_n[5] = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); pulses += int'(parity_error); end
    checks++;
    if (pulses != 1 || error_count !== 8'd1) begin
      errors++;
      $display("FAIL single_bad: got pulses %0d count %0d, expected 1 1", pulses, error_count);
    end
    a_tag_in_n[5] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    pulses = 0;
    for (int s = 0; s < 300; s++) begin
      a_tag_in_n[5 + (s % 2)] = 1'b0;
      for (int i = 0; i < 4; i++) begin step(); pulses += int'(parity_error); end
      a_tag_in_n = '1;
      for (int i = 0; i < 4; i++) begin step(); pulses += int'(parity_error); end
    end
    for (int i = 0; i < 8; i++) begin step(); pulses += int'(parity_error); end
    checks++;
    if (pulses != 300 || error_count !== 8'd255) begin
      errors++;
      $display("FAIL saturate: got pulses %0d count %0d, expected 300 255", pulses, error_count);
    end
    clear_errors = 1'b1;
    pulses = 0;
    a_tag_in_n[6] = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(parity_error); end
    checks++;
    if (pulses != 1 || error_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_priority: got pulses %0d count %0d, expected 1 0", pulses, error_count);
    end
    clear_errors = 1'b0; a_tag_in_n = '1;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_disabled();
    enable = 1'b0; wrap_test = 1'b1;
    for (int i = 0; i < 14; i++) begin
      b_tag_out = 12'($urandom) | 12'h005;
      b_bus_out = 8'($urandom); b_bus_out_parity = 1'($urandom);
      a_bus_in_n = 8'($urandom); a_tag_in_n = 10'($urandom) & 10'h39F;
      step();
      if (i >= 4) begin
        checks++;
        if (all_out[49:8] !== 42'h0) begin
          errors++;
          $display("FAIL disabled_outputs: got %0h, expected 0", all_out[49:8]);
        end
      end
    end
    wrap_test = 1'b0; enable = 1'b1; a_tag_in_n = '1; b_tag_out = '0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) wrap_test = ~wrap_test;
      clear_errors = ($urandom_range(0, 49) == 0);
      b_tag_out[11:1] = 11'($urandom);
      if ($urandom_range(0, 15) == 0) b_tag_out[0] = ~b_tag_out[0];
      b_bus_out = 8'($urandom); b_bus_out_parity = 1'($urandom);
      a_bus_in_n = 8'($urandom); a_bus_in_parity_n = 1'($urandom);
      for (int b = 0; b < 10; b++) if ($urandom_range(0, 4) == 0) a_tag_in_n[b] = ~a_tag_in_n[b];
      step();
      checks++;
      if ({b_bus_in_parity, b_bus_in} !== e_bbus[n]) begin
        errors++;
        $display("FAIL rnd_b_bus_in cyc %0d: got %0h, expected %0h", n, {b_bus_in_parity, b_bus_in}, e_bbus[n]);
      end
      checks++;
      if (b_tag_in !== e_btag[n]) begin
        errors++;
        $display("FAIL rnd_b_tag_in cyc %0d: got %0h, expected %0h", n, b_tag_in, e_btag[n]);
      end
      checks++;
      if ({a_tag_out, a_bus_out_parity, a_bus_out} !== {e_atag[n], e_abus[n]}) begin
        errors++;
        $display("FAIL rnd_a_out cyc %0d: got %0h, expected %0h", n, {a_tag_out, a_bus_out_parity, a_bus_out}, {e_atag[n], e_abus[n]});
      end
      checks++;
      if (driver_enable !== e_drv[n]) begin
        errors++;
        $display("FAIL rnd_driver cyc %0d: got %0b, expected %0b", n, driver_enable, e_drv[n]);
      end
      checks++;
      if (parity_error !== e_perr[n] || error_count !== e_cnt[n]) begin
        errors++;
        $display("FAIL rnd_parity cyc %0d: got %0b/%0d, expected %0b/%0d", n, parity_error, error_count, e_perr[n], e_cnt[n]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic reached;
    enable = 1'b1; wrap_test = 1'b1; clear_errors = 1'b0; b_tag_out = '0;
    a_bus_in_n = '1; a_bus_in_parity_n = 1'b1; a_tag_in_n = 10'h3FB;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin step(); reached = driver_enable; end
    step(); step();
    checks++;
    if (reached !== 1'b1 || b_tag_in[2] !== 1'b1) begin
      errors++;
      $display("FAIL reach_on: got drv %0b tag2 %0b, expected 1 1", reached, b_tag_in[2]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 50'h0) begin
      errors++;
      $display("FAIL async_reset: got %0h, expected 0", all_out);
    end
    step();
    a_tag_in_n = '1; wrap_test = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (b_tag_in !== 10'h0 || driver_enable !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: got tag %0h drv %0b, expected 0 0", b_tag_in, driver_enable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tag_latency();
    test_glitch();
    test_driver();
    test_parity();
    test_disabled();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
